// File: rtl/seg_readback.sv
// Seven-segment readback decoder: snapshots the eight HEX patterns, decodes them into a 32-bit value,
// filters for stability and offers each new result over valid/ready. Optional macro: SEG_READBACK_DP_CHECK_EN.
module seg_readback #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0][7:0] segs,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     value,
  output logic [7:0]      blank,
  output logic [7:0]      digit_err
);

  typedef enum logic [1:0] {IDLE, SCAN, CHECK, PRESENT} state_t;

  localparam logic [3:0] STABLE_MAX = 4'(STABLE_CYCLES);

  state_t          state;
  state_t          state_next;
  logic [2:0]      idx;
  logic [7:0][7:0] cap;
  logic [31:0]     work_value;
  logic [7:0]      work_blank;
  logic [7:0]      work_err;
  logic [47:0]     work_tuple;
  logic [47:0]     prev_tuple;
  logic [47:0]     last_tuple;
  logic [3:0]      cnt;
  logic [3:0]      cnt_next;
  logic            emitted;
  logic            emit_now;
  logic [5:0]      dec;

  // Returns {err, blank, nibble} for one digit pattern.
  function automatic logic [5:0] decode_digit(input logic [7:0] pat);
    logic [5:0] r;
    r = 6'b10_0000;
    case (pat[6:0])
      7'h40: r = 6'b00_0000;
      7'h79: r = 6'b00_0001;
      7'h24: r = 6'b00_0010;
      7'h30: r = 6'b00_0011;
      7'h19: r = 6'b00_0100;
      7'h12: r = 6'b00_0101;
      7'h02: r = 6'b00_0110;
      7'h78: r = 6'b00_0111;
      7'h00: r = 6'b00_1000;
      7'h10: r = 6'b00_1001;
      7'h08: r = 6'b00_1010;
      7'h03: r = 6'b00_1011;
      7'h46: r = 6'b00_1100;
      7'h21: r = 6'b00_1101;
      7'h06: r = 6'b00_1110;
      7'h0E: r = 6'b00_1111;
      7'h7F: r = 6'b01_0000;
      default: r = 6'b10_0000;
    endcase
`ifdef SEG_READBACK_DP_CHECK_EN
    // A lit decimal point is never a legal glyph, which also makes a blank require 0xFF.
    if (!pat[7]) r = 6'b10_0000;
`endif
    return r;
  endfunction

  assign dec        = decode_digit(cap[idx]);
  assign work_tuple = {work_value, work_blank, work_err};

  always_comb begin
    if (work_tuple != prev_tuple) cnt_next = 4'd1;
    else if (cnt >= STABLE_MAX)   cnt_next = STABLE_MAX;
    else                          cnt_next = cnt + 4'd1;
  end

  // A stable tuple is offered only once until a different one has been emitted.
  assign emit_now = (cnt_next == STABLE_MAX) && (!emitted || (work_tuple != last_tuple));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = SCAN;
      SCAN:    if (idx == 3'd7) state_next = CHECK;
      CHECK:   state_next = emit_now ? PRESENT : IDLE;
      PRESENT: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state == PRESENT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx        <= 3'd0;
      cap        <= '0;
      work_value <= '0;
      work_blank <= '0;
      work_err   <= '0;
      prev_tuple <= '0;
      last_tuple <= '0;
      cnt        <= 4'd0;
      emitted    <= 1'b0;
      value      <= '0;
      blank      <= '0;
      digit_err  <= '0;
    end else begin
      case (state)
        IDLE: begin
          cap <= segs;
          idx <= 3'd0;
        end
        SCAN: begin
          work_value[{idx, 2'b00} +: 4] <= dec[3:0];
          work_blank[idx]               <= dec[4];
          work_err[idx]                 <= dec[5];
          idx                           <= idx + 3'd1;
        end
        CHECK: begin
          prev_tuple <= work_tuple;
          cnt        <= cnt_next;
          if (emit_now) begin
            value     <= work_value;
            blank     <= work_blank;
            digit_err <= work_err;
          end
        end
        PRESENT: begin
          if (out_ready) begin
            last_tuple <= {value, blank, digit_err};
            emitted    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/seg_readback.md
# seg_readback

Display-side readback decoder: samples the eight active-low DE2-115 seven-segment patterns driven to the HEX digits and reconstructs the 32-bit hex value they show. A stability filter suppresses transient patterns. Each newly stable result is offered through a valid/ready handshake. It sits beside the display driver in the FPGA top level and feeds a self-check or debug UART path.

## Interface
- `STABLE_CYCLES`, default 4: consecutive identical samples required before a result is emitted; legal range 1..15.
- `clk` input 1: single clock, all state on rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `segs[7:0]` input 8 bits each: active-low segment pattern per digit.
  - Index k is nibble k: digit 0 maps to value[3:0].
  - Bits [6:0] are segments g..a; bit 7 is the decimal point.
- `out_valid` output 1: decoded result available.
- `out_ready` input 1: consumer accepts the result.
- `value` output 32: decoded hex value.
- `blank` output 8: bit k set means digit k is blank.
- `digit_err` output 8: bit k set means digit k is the error glyph or an unknown pattern.

## Operation
- Decode compares bits [6:0] only, unless the configuration macro is defined.
- Hex glyphs:
  - 0=0x40, 1=0x79, 2=0x24, 3=0x30
  - 4=0x19, 5=0x12, 6=0x02, 7=0x78
  - 8=0x00, 9=0x10, A=0x08, b=0x03
  - C=0x46, d=0x21, E=0x06, F=0x0E
- Special patterns:
  - 0x7F (blank): nibble 0, `blank[k]`=1.
  - 0x36 (error glyph) or any other pattern: nibble 0, `digit_err[k]`=1.
- FSM states:
  - IDLE: snapshot all eight `segs` into a capture register (1 cycle), then go to SCAN.
  - SCAN: decode one digit per cycle, index 0..7, into a work tuple (value, blank, digit_err); after index 7 go to CHECK.
  - CHECK (1 cycle): compare the work tuple with the previous sample's tuple.
    - Equal: stable counter increments, saturating at STABLE_CYCLES.
    - Different: counter loads 1.
    - If counter == STABLE_CYCLES and (nothing emitted since reset, or tuple ≠ last emitted tuple): load outputs, set `out_valid`, go to PRESENT.
    - Otherwise go to IDLE.
  - PRESENT: hold `out_valid` and the outputs until `out_valid && out_ready`; the tuple becomes "last emitted"; go to IDLE. No sampling occurs while in PRESENT.
- Counter arithmetic: 4-bit counter, saturating, never wraps.
- An already-emitted stable tuple is never re-emitted until a different tuple has been emitted.

## Timing
- Reset values: `out_valid`=0, `value`=0, `blank`=0, `digit_err`=0, state IDLE, counter 0, emitted flag clear. Asserting `rst` clears these immediately, including mid-SCAN or in PRESENT.
- Sample period is 10 cycles (IDLE 1 + SCAN 8 + CHECK 1) while not presenting.
- With input constant from reset release, `out_valid` rises on edge 10·STABLE_CYCLES counted from the first post-reset edge.
- `value`, `blank` and `digit_err` change only on the edge that raises `out_valid`, and stay stable while it is high.
- If `out_ready` is already high when `out_valid` rises, the handshake completes on the next edge. `out_valid` is therefore high for at least 1 cycle.
- After a handshake, the next sampling starts in the following cycle, with the stable counter retained.
- `segs` changing during SCAN has no effect, because decoding uses the snapshot.

## Configuration
- `SEG_READBACK_DP_CHECK_EN` defined:
  - Bit 7 must be 1 (dp off); bit 7 = 0 sets `digit_err[k]` and forces nibble 0.
  - A blank pattern requires byte 0xFF.
- Undefined: bit 7 is ignored entirely.

## Test plan
- Reset release with all `segs`=0x40, `out_ready`=1 -> `out_valid` pulses at edge 40, `value`=0x00000000, `blank`=0, `digit_err`=0; no second pulse over 200 cycles.
- `segs` encoding 0x1234ABCD (digit7..0 = 0x79,0x24,0x30,0x19,0x08,0x03,0x46,0x21) -> `value`=0x1234ABCD once, after 4 identical samples.
- Digit 3=0x7F, digit 5=0x55, others 0x40 -> `blank`=0x08, `digit_err`=0x20, `value`=0.
- Emit 0x0, then change digit 0 to 0x79 for one sample window only and restore -> no new `out_valid`.
- Hold `out_ready`=0 for 60 cycles while `out_valid`=1 and change `segs` to show 0x5 -> outputs frozen; after the handshake, 0x00000005 is emitted 40 cycles later.
- Assert `rst` mid-SCAN and mid-PRESENT -> outputs 0 at once; re-emission follows the 10·STABLE_CYCLES rule. With the macro defined, digit 0=0x40 (dp on) -> `digit_err`=0x01.
